// File: rtl/apb_regfile_slave.sv
// APB3 completer: word-addressed register file with programmable wait states.
// Optional byte strobes (pstrb_i) when APB_SLV_PSTRB_EN is defined.
//
// state  | meaning
// S_IDLE | no transfer in progress; an access phase with WAIT_CYCLES=0 goes straight to S_DONE
// S_WAIT | inserting wait states; cnt counts access cycles already spent
// S_DONE | pready_o high for one cycle; write commits on the edge leaving this state
module apb_regfile_slave #(
   parameter int          NUM_REGS    = 8,
   parameter int          WAIT_CYCLES = 0,
   parameter logic [31:0] BASE_ADDR   = 32'h0
) (
   input  logic        pclk,
   input  logic        preset_n,
   input  logic        psel_i,
   input  logic        penable_i,
   input  logic [31:0] paddr_i,
   input  logic        pwrite_i,
   input  logic [31:0] pwdata_i,
`ifdef APB_SLV_PSTRB_EN
   input  logic [3:0]  pstrb_i,
`endif
   output logic [31:0] prdata_o,
   output logic        pready_o,
   output logic        pslverr_o
);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

   localparam logic [3:0]  WAIT_C   = 4'(WAIT_CYCLES);
   localparam logic [29:0] BASE_IDX = BASE_ADDR[31:2];
   localparam logic [29:0] NUM_IDX  = 30'(NUM_REGS);

   state_t        state, state_nxt;
   logic [3:0]    cnt, cnt_nxt;
   logic [29:0]   idx;
   logic          err;
   logic          access;
   logic          wr_en;
   logic [31:0]   rd_word;
   logic [31:0]   wr_mask;
   logic [31:0]   regs [NUM_REGS];

   // BASE_ADDR is aligned and misaligned addresses are errors, so word indices subtract directly
   assign idx    = paddr_i[31:2] - BASE_IDX;
   assign err    = (paddr_i[1:0] != 2'b00) | (paddr_i < BASE_ADDR) | (idx >= NUM_IDX);
   assign access = psel_i & penable_i;
   assign wr_en  = (state == S_DONE) & access & pwrite_i & ~err;

`ifdef APB_SLV_PSTRB_EN
   assign wr_mask = {{8{pstrb_i[3]}}, {8{pstrb_i[2]}}, {8{pstrb_i[1]}}, {8{pstrb_i[0]}}};
`else
   assign wr_mask = '1;
`endif

   always_comb begin
      rd_word = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (idx == 30'(i)) rd_word = regs[i];
      end
   end

   // Access cycle 0 is spent in S_IDLE, so the counter starts at 1 on entering S_WAIT
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         S_IDLE: begin
            if (access) begin
               if (WAIT_C == 4'd0) begin
                  state_nxt = S_DONE;
                  cnt_nxt   = 4'd0;
               end else begin
                  state_nxt = S_WAIT;
                  cnt_nxt   = 4'd1;
               end
            end
         end
         S_WAIT: begin
            if (!psel_i) begin
               state_nxt = S_IDLE;
               cnt_nxt   = 4'd0;
            end else if (cnt == WAIT_C) begin
               state_nxt = S_DONE;
               cnt_nxt   = 4'd0;
            end else begin
               cnt_nxt = cnt + 4'd1;
            end
         end
         S_DONE: begin
            state_nxt = S_IDLE;
            cnt_nxt   = 4'd0;
         end
         default: begin
            state_nxt = S_IDLE;
            cnt_nxt   = 4'd0;
         end
      endcase
   end

   always_ff @(posedge pclk or negedge preset_n) begin
      if (!preset_n) begin
         state     <= S_IDLE;
         cnt       <= 4'd0;
         prdata_o  <= '0;
         pready_o  <= 1'b0;
         pslverr_o <= 1'b0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         pready_o  <= (state_nxt == S_DONE);
         pslverr_o <= (state_nxt == S_DONE) & err;
         if ((state_nxt == S_DONE) && !pwrite_i) prdata_o <= err ? '0 : rd_word;
      end
   end

   always_ff @(posedge pclk or negedge preset_n) begin
      if (!preset_n) begin
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      end else if (wr_en) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            if (idx == 30'(i)) regs[i] <= (regs[i] & ~wr_mask) | (pwdata_i & wr_mask);
         end
      end
   end

endmodule

// File: tb/tb_apb_regfile_slave.sv
// Bench for apb_regfile_slave: three instances with WAIT_CYCLES 0, 3 and 2 on separate select lines.
module tb_apb_regfile_slave;

   logic        pclk;
   logic        preset_n;
   logic        psel    [3];
   logic        penable [3];
   logic [31:0] paddr;
   logic        pwrite;
   logic [31:0] pwdata;
   logic [3:0]  pstrb;
   logic [31:0] prdata  [3];
   logic        pready  [3];
   logic        pslverr [3];

   int n_vec = 0;
   int n_err = 0;

   initial pclk = 1'b0;
   always #5 pclk = ~pclk;

   apb_regfile_slave #(.NUM_REGS(8), .WAIT_CYCLES(0), .BASE_ADDR(32'h0)) u_w0 (
      .pclk(pclk), .preset_n(preset_n), .psel_i(psel[0]), .penable_i(penable[0]),
      .paddr_i(paddr), .pwrite_i(pwrite), .pwdata_i(pwdata),
`ifdef APB_SLV_PSTRB_EN
      .pstrb_i(pstrb),
`endif
      .prdata_o(prdata[0]), .pready_o(pready[0]), .pslverr_o(pslverr[0]));

   apb_regfile_slave #(.NUM_REGS(8), .WAIT_CYCLES(3), .BASE_ADDR(32'h0)) u_w3 (
      .pclk(pclk), .preset_n(preset_n), .psel_i(psel[1]), .penable_i(penable[1]),
      .paddr_i(paddr), .pwrite_i(pwrite), .pwdata_i(pwdata),
`ifdef APB_SLV_PSTRB_EN
      .pstrb_i(pstrb),
`endif
      .prdata_o(prdata[1]), .pready_o(pready[1]), .pslverr_o(pslverr[1]));

   apb_regfile_slave #(.NUM_REGS(8), .WAIT_CYCLES(2), .BASE_ADDR(32'h0)) u_w2 (
      .pclk(pclk), .preset_n(preset_n), .psel_i(psel[2]), .penable_i(penable[2]),
      .paddr_i(paddr), .pwrite_i(pwrite), .pwdata_i(pwdata),
`ifdef APB_SLV_PSTRB_EN
      .pstrb_i(pstrb),
`endif
      .prdata_o(prdata[2]), .pready_o(pready[2]), .pslverr_o(pslverr[2]));

   typedef struct {
      int          dut;
      bit          wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  strb;
      logic [31:0] exp_rdata;
      logic        exp_err;
      int          exp_lat;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic add(input int d, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                      input logic [3:0] st, input logic [31:0] rd, input logic e, input int lat);
      vec_t v;
      v.dut = d; v.wr = wr; v.addr = a; v.wdata = wd; v.strb = st;
      v.exp_rdata = rd; v.exp_err = e; v.exp_lat = lat;
      vecs.push_back(v);
   endtask

   // Setup phase, then access phase held until pready; lat = access cycle in which pready is seen
   task automatic xfer(input int d, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] st, output logic [31:0] rd, output logic e, output int lat);
      int cyc;
      @(posedge pclk); #1;
      psel[d] = 1'b1; penable[d] = 1'b0;
      paddr = a; pwrite = wr; pwdata = wd; pstrb = st;
      @(posedge pclk); #1;
      penable[d] = 1'b1;
      lat = -1; rd = '0; e = 1'b0;
      for (cyc = 0; cyc < 40; cyc++) begin
         @(negedge pclk);
         if (pready[d]) begin
            lat = cyc; rd = prdata[d]; e = pslverr[d];
            break;
         end
         @(posedge pclk); #1;
      end
      if (lat < 0) $display("FAIL timeout: dut %0d got no pready expected one within 40 cycles", d);
      @(posedge pclk); #1;
      psel[d] = 1'b0; penable[d] = 1'b0;
   endtask

   initial begin
      logic [31:0] rd;
      logic        e;
      int          lat;
      bit          seen;

      preset_n = 1'b0;
      for (int i = 0; i < 3; i++) begin psel[i] = 1'b0; penable[i] = 1'b0; end
      paddr = '0; pwrite = 1'b0; pwdata = '0; pstrb = 4'hF;

      repeat (3) @(posedge pclk);
      @(negedge pclk);
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("rst_prdata%0d", i), prdata[i], 32'h0);
         chk($sformatf("rst_pready%0d", i), {31'b0, pready[i]}, 32'h0);
         chk($sformatf("rst_pslverr%0d", i), {31'b0, pslverr[i]}, 32'h0);
      end
      @(posedge pclk); #1;
      preset_n = 1'b1;

      add(0, 0, 32'h0,  32'h0,        4'hF, 32'h0,        1'b0, 1);
      add(0, 1, 32'h8,  32'hDEADBEEF, 4'hF, 32'h0,        1'b0, 1);
      add(0, 0, 32'h8,  32'h0,        4'hF, 32'hDEADBEEF, 1'b0, 1);
      add(0, 1, 32'h20, 32'h1234,     4'hF, 32'h0,        1'b1, 1);
      add(0, 1, 32'h2,  32'h1234,     4'hF, 32'h0,        1'b1, 1);
      for (int i = 0; i < 8; i++)
         add(0, 0, 32'(i * 4), 32'h0, 4'hF, (i == 2) ? 32'hDEADBEEF : 32'h0, 1'b0, 1);
      add(0, 0, 32'h20, 32'h0,        4'hF, 32'h0,        1'b1, 1);
      add(0, 0, 32'h3,  32'h0,        4'hF, 32'h0,        1'b1, 1);
      add(0, 1, 32'h1C, 32'hCAFEF00D, 4'hF, 32'h0,        1'b0, 1);
      add(0, 0, 32'h1C, 32'h0,        4'hF, 32'hCAFEF00D, 1'b0, 1);
      add(1, 0, 32'h4,  32'h0,        4'hF, 32'h0,        1'b0, 4);
      add(1, 1, 32'h4,  32'h600DF00D, 4'hF, 32'h0,        1'b0, 4);
      add(1, 0, 32'h4,  32'h0,        4'hF, 32'h600DF00D, 1'b0, 4);
      add(2, 1, 32'h0,  32'h55,       4'hF, 32'h0,        1'b0, 3);
      add(2, 0, 32'h0,  32'h0,        4'hF, 32'h55,       1'b0, 3);

      for (int k = 0; k < vecs.size(); k++) begin
         xfer(vecs[k].dut, vecs[k].wr, vecs[k].addr, vecs[k].wdata, vecs[k].strb, rd, e, lat);
         chk($sformatf("v%0d_lat", k), 32'(lat), 32'(vecs[k].exp_lat));
         chk($sformatf("v%0d_err", k), {31'b0, e}, {31'b0, vecs[k].exp_err});
         if (!vecs[k].wr) chk($sformatf("v%0d_rdata", k), rd, vecs[k].exp_rdata);
      end

      // pready/pslverr last one cycle; a write leaves prdata at the last read value
      xfer(0, 0, 32'h8, 32'h0, 4'hF, rd, e, lat);
      xfer(0, 1, 32'h24, 32'h77, 4'hF, rd, e, lat);
      chk("err_write_pslverr", {31'b0, e}, 32'h1);
      @(negedge pclk);
      chk("pready_one_cycle", {31'b0, pready[0]}, 32'h0);
      chk("pslverr_clears", {31'b0, pslverr[0]}, 32'h0);
      chk("prdata_hold", prdata[0], 32'hDEADBEEF);

      // abort: psel drops in access cycle 1 of a write on the WAIT_CYCLES=2 instance
      @(posedge pclk); #1;
      psel[2] = 1'b1; penable[2] = 1'b0; paddr = 32'h0; pwrite = 1'b1; pwdata = 32'hAAAA;
      @(posedge pclk); #1;
      penable[2] = 1'b1;
      @(posedge pclk); #1;
      psel[2] = 1'b0; penable[2] = 1'b0;
      seen = 1'b0;
      repeat (6) begin
         @(negedge pclk);
         if (pready[2]) seen = 1'b1;
      end
      chk("abort_no_pready", {31'b0, seen}, 32'h0);
      chk("abort_prdata_kept", prdata[2], 32'h55);
      xfer(2, 0, 32'h0, 32'h0, 4'hF, rd, e, lat);
      chk("abort_reg0_kept", rd, 32'h55);

      // reset in the middle of a wait
      @(posedge pclk); #1;
      psel[2] = 1'b1; penable[2] = 1'b0; paddr = 32'h0; pwrite = 1'b0;
      @(posedge pclk); #1;
      penable[2] = 1'b1;
      @(posedge pclk); #2;
      preset_n = 1'b0;
      #1;
      chk("midrst_prdata", prdata[2], 32'h0);
      chk("midrst_pready", {31'b0, pready[2]}, 32'h0);
      chk("midrst_pslverr", {31'b0, pslverr[2]}, 32'h0);
      chk("midrst_prdata_w0", prdata[0], 32'h0);
      psel[2] = 1'b0; penable[2] = 1'b0;
      @(posedge pclk); #1;
      preset_n = 1'b1;
      xfer(2, 0, 32'h0, 32'h0, 4'hF, rd, e, lat);
      chk("post_rst_reg0", rd, 32'h0);
      chk("post_rst_lat", 32'(lat), 32'd3);

`ifdef APB_SLV_PSTRB_EN
      xfer(0, 1, 32'h4, 32'hFFFFFFFF, 4'hF, rd, e, lat);
      xfer(0, 1, 32'h4, 32'h00000000, 4'b0101, rd, e, lat);
      chk("strb_write_err", {31'b0, e}, 32'h0);
      xfer(0, 0, 32'h4, 32'h0, 4'hF, rd, e, lat);
      chk("strb_0101", rd, 32'hFF00FF00);
      xfer(0, 1, 32'h4, 32'h12345678, 4'b0000, rd, e, lat);
      chk("strb_none_err", {31'b0, e}, 32'h0);
      chk("strb_none_lat", 32'(lat), 32'd1);
      xfer(0, 0, 32'h4, 32'h0, 4'hF, rd, e, lat);
      chk("strb_none_kept", rd, 32'hFF00FF00);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
